// File: rtl/better_neighbors_in_my_cluster.sv
// better_neighbors_in_my_cluster
// Scans the shared neighbour table for same-cluster neighbours whose Q-value beats
// the node's own best cost. It lists their IDs in betterneighbors[], writes the
// list count, and reports the best such neighbour to the winner-policy stage.
// Memory reads have 1-cycle latency: an address state is followed by a latch state.
// Optional feature macro: BNIMC_EQUAL_BETTER_EN
//   defined   -> better test is q <= mybest; best-tracking ties take the later neighbour
//   undefined -> better test is q <  mybest; best-tracking ties keep the earlier neighbour
module better_neighbors_in_my_cluster #(
  parameter int unsigned            WORD_WIDTH        = 16,
  parameter logic [WORD_WIDTH-1:0]  NBR_COUNT_ADDR    = 16'h068A,
  parameter logic [WORD_WIDTH-1:0]  NBR_ID_BASE       = 16'h0048,
  parameter logic [WORD_WIDTH-1:0]  CLUSTER_BASE      = 16'h00C8,
  parameter logic [WORD_WIDTH-1:0]  QVAL_BASE         = 16'h01C8,
  parameter logic [WORD_WIDTH-1:0]  SINKCNT_BASE      = 16'h068E,
  parameter logic [WORD_WIDTH-1:0]  BETTER_BASE       = 16'h0668,
  parameter logic [WORD_WIDTH-1:0]  BETTER_COUNT_ADDR = 16'h068C,
  parameter int unsigned            MAX_NBR           = 64,
  parameter int unsigned            MAX_BETTER        = 16
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  start,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
  input  logic [WORD_WIDTH-1:0] mybest,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] bestvalue,
  output logic [WORD_WIDTH-1:0] bestneighborID,
  output logic [WORD_WIDTH-1:0] nextsinks,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  done
);

  localparam int unsigned NW = $clog2(MAX_NBR + 1);
  localparam int unsigned KW = $clog2(MAX_BETTER + 1);

  typedef enum logic [3:0] {
    StIdle, StCntA, StCntL, StClA, StClL, StQA, StQL, StIdA,
    StIdL, StWrBet, StBest, StScA, StScL, StNext, StWrCnt, StDone
  } state_e;

  state_e                r_state, w_state;
  logic [WORD_WIDTH-1:0] r_address, w_address;
  logic                  r_wr_en, w_wr_en;
  logic [WORD_WIDTH-1:0] r_data_out, w_data_out;
  logic                  r_done, w_done;
  logic [WORD_WIDTH-1:0] r_besthop, w_besthop;
  logic [WORD_WIDTH-1:0] r_bestvalue, w_bestvalue;
  logic [WORD_WIDTH-1:0] r_bestid, w_bestid;
  logic [WORD_WIDTH-1:0] r_nextsinks, w_nextsinks;
  logic [NW-1:0]         r_n, w_n;
  logic [NW-1:0]         r_i, w_i;
  logic [KW-1:0]         r_k, w_k;
  logic [WORD_WIDTH-1:0] r_q, w_q;
  logic [WORD_WIDTH-1:0] r_id, w_id;

  logic [NW-1:0]         w_n_clamped;
  logic [NW-1:0]         w_i_inc;
  logic                  w_better;
  logic                  w_take;

  // Word address of entry idx in a table of 16-bit words; wraps at 16 bits
  function automatic logic [WORD_WIDTH-1:0] addr_of(input logic [WORD_WIDTH-1:0] base,
                                                    input logic [WORD_WIDTH-1:0] idx);
    return base + (idx << 1);
  endfunction

  assign w_n_clamped = (data_in > WORD_WIDTH'(MAX_NBR)) ? NW'(MAX_NBR) : NW'(data_in);
  assign w_i_inc     = r_i + NW'(1);

`ifdef BNIMC_EQUAL_BETTER_EN
  assign w_better = (data_in <= mybest);
  assign w_take   = (r_q <= r_bestvalue);
`else
  assign w_better = (data_in < mybest);
  assign w_take   = (r_q < r_bestvalue);
`endif

  // Next-state and next-register values; outputs are registered and change only on transitions
  always_comb begin
    w_state     = r_state;
    w_address   = r_address;
    w_wr_en     = 1'b0;
    w_data_out  = r_data_out;
    w_done      = r_done;
    w_besthop   = r_besthop;
    w_bestvalue = r_bestvalue;
    w_bestid    = r_bestid;
    w_nextsinks = r_nextsinks;
    w_n         = r_n;
    w_i         = r_i;
    w_k         = r_k;
    w_q         = r_q;
    w_id        = r_id;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state   = StCntA;
          w_address = NBR_COUNT_ADDR;
        end
      end
      StCntA: w_state = StCntL;
      StCntL: begin
        w_n = w_n_clamped;
        w_i = '0;
        if (w_n_clamped == '0) begin
          w_state    = StWrCnt;
          w_address  = BETTER_COUNT_ADDR;
          w_data_out = WORD_WIDTH'(r_k);
          w_wr_en    = 1'b1;
        end else begin
          w_state   = StClA;
          w_address = CLUSTER_BASE;
        end
      end
      StClA: w_state = StClL;
      StClL: begin
        if (data_in == MY_CLUSTER_ID) begin
          w_state   = StQA;
          w_address = addr_of(QVAL_BASE, WORD_WIDTH'(r_i));
        end else begin
          w_state = StNext;
        end
      end
      StQA: w_state = StQL;
      StQL: begin
        w_q = data_in;
        if (w_better) begin
          w_state   = StIdA;
          w_address = addr_of(NBR_ID_BASE, WORD_WIDTH'(r_i));
        end else begin
          w_state = StNext;
        end
      end
      StIdA: w_state = StIdL;
      StIdL: begin
        w_id = data_in;
        // A full list drops the write but the neighbour still competes for best
        if (r_k < KW'(MAX_BETTER)) begin
          w_state    = StWrBet;
          w_address  = addr_of(BETTER_BASE, WORD_WIDTH'(r_k));
          w_data_out = data_in;
          w_wr_en    = 1'b1;
        end else begin
          w_state = StBest;
        end
      end
      StWrBet: begin
        w_k     = r_k + KW'(1);
        w_state = StBest;
      end
      StBest: begin
        if (w_take) begin
          w_bestvalue = r_q;
          w_bestid    = r_id;
          w_besthop   = WORD_WIDTH'(r_i);
          w_state     = StScA;
          w_address   = addr_of(SINKCNT_BASE, WORD_WIDTH'(r_i));
        end else begin
          w_state = StNext;
        end
      end
      StScA: w_state = StScL;
      StScL: begin
        w_nextsinks = data_in;
        w_state     = StNext;
      end
      StNext: begin
        w_i = w_i_inc;
        if (w_i_inc == r_n) begin
          w_state    = StWrCnt;
          w_address  = BETTER_COUNT_ADDR;
          w_data_out = WORD_WIDTH'(r_k);
          w_wr_en    = 1'b1;
        end else begin
          w_state   = StClA;
          w_address = addr_of(CLUSTER_BASE, WORD_WIDTH'(w_i_inc));
        end
      end
      StWrCnt: begin
        w_state = StDone;
        w_done  = 1'b1;
      end
      StDone: w_state = StDone;
      default: w_state = StIdle;
    endcase
  end

  // State and datapath registers; nrst is a synchronous active-high reset
  always_ff @(posedge clock) begin
    if (nrst) begin
      r_state     <= StIdle;
      r_address   <= '0;
      r_wr_en     <= 1'b0;
      r_data_out  <= '0;
      r_done      <= 1'b0;
      r_besthop   <= '0;
      r_bestvalue <= '1;
      r_bestid    <= '1;
      r_nextsinks <= '0;
      r_n         <= '0;
      r_i         <= '0;
      r_k         <= '0;
      r_q         <= '0;
      r_id        <= '0;
    end else begin
      r_state     <= w_state;
      r_address   <= w_address;
      r_wr_en     <= w_wr_en;
      r_data_out  <= w_data_out;
      r_done      <= w_done;
      r_besthop   <= w_besthop;
      r_bestvalue <= w_bestvalue;
      r_bestid    <= w_bestid;
      r_nextsinks <= w_nextsinks;
      r_n         <= w_n;
      r_i         <= w_i;
      r_k         <= w_k;
      r_q         <= w_q;
      r_id        <= w_id;
    end
  end

  assign address        = r_address;
  assign wr_en          = r_wr_en;
  assign data_out       = r_data_out;
  assign done           = r_done;
  assign besthop        = r_besthop;
  assign bestvalue      = r_bestvalue;
  assign bestneighborID = r_bestid;
  assign nextsinks      = r_nextsinks;

endmodule

// File: tb/tb_better_neighbors_in_my_cluster.sv
// Directed bench for better_neighbors_in_my_cluster with a 1-cycle-latency word memory.
module tb_better_neighbors_in_my_cluster;

  localparam logic [15:0] A_NCNT = 16'h068A;
  localparam logic [15:0] A_ID   = 16'h0048;
  localparam logic [15:0] A_CL   = 16'h00C8;
  localparam logic [15:0] A_Q    = 16'h01C8;
  localparam logic [15:0] A_SC   = 16'h068E;
  localparam logic [15:0] A_BET  = 16'h0668;
  localparam logic [15:0] A_BCNT = 16'h068C;

  logic        clock;
  logic        nrst;
  logic        start;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] data_in;
  logic [15:0] my_cluster;
  logic [15:0] mybest;
  logic [15:0] besthop;
  logic [15:0] bestvalue;
  logic [15:0] bestneighborID;
  logic [15:0] nextsinks;
  logic [15:0] data_out;
  logic        done;

  logic [15:0] mem [0:2047];
  logic [15:0] img [0:2047];
  logic        load_mem;
  int          n_wr;
  int          n_total;
  int          n_bad;

  better_neighbors_in_my_cluster dut (
    .clock          (clock),
    .nrst           (nrst),
    .start          (start),
    .address        (address),
    .wr_en          (wr_en),
    .data_in        (data_in),
    .MY_CLUSTER_ID  (my_cluster),
    .mybest         (mybest),
    .besthop        (besthop),
    .bestvalue      (bestvalue),
    .bestneighborID (bestneighborID),
    .nextsinks      (nextsinks),
    .data_out       (data_out),
    .done           (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared memory: registered read, write on wr_en, bulk load from the image
  always @(posedge clock) begin
    data_in <= mem[address[11:1]];
    if (load_mem) begin
      mem  <= img;
      n_wr <= 0;
    end else if (wr_en) begin
      mem[address[11:1]] <= data_out;
      n_wr <= n_wr + 1;
    end
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem[a[11:1]];
  endfunction

  task automatic set_word(input logic [15:0] a, input logic [15:0] v);
    img[a[11:1]] = v;
  endtask

  task automatic clear_img(input logic [15:0] n);
    for (int j = 0; j < 2048; j++) img[j] = 16'h0000;
    set_word(A_NCNT, n);
    set_word(A_BCNT, 16'h5555);
    set_word(16'h0688, 16'hBEEF);
  endtask

  task automatic set_nbr(input int i, input logic [15:0] cl, input logic [15:0] q,
                         input logic [15:0] id, input logic [15:0] sc);
    set_word(A_CL + 16'(2 * i), cl);
    set_word(A_Q  + 16'(2 * i), q);
    set_word(A_ID + 16'(2 * i), id);
    set_word(A_SC + 16'(2 * i), sc);
  endtask

  // Hold reset while loading memory, then release
  task automatic load_and_reset();
    @(negedge clock);
    nrst     = 1'b1;
    start    = 1'b0;
    load_mem = 1'b1;
    @(negedge clock);
    load_mem = 1'b0;
    @(negedge clock);
    nrst = 1'b0;
  endtask

  // One-cycle start pulse; the scan must run to completion regardless
  task automatic run(input string tag);
    logic seen;
    seen  = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    check_val({tag, "_done"}, {15'd0, seen}, 16'd1);
  endtask

  task automatic setup_three();
    clear_img(16'd3);
    set_nbr(0, 16'd1, 16'd8, 16'd7, 16'd2);
    set_nbr(1, 16'd1, 16'd4, 16'd8, 16'd4);
    set_nbr(2, 16'd1, 16'd6, 16'd9, 16'd6);
  endtask

  task automatic check_three(input string tag);
    check_val({tag, "_l0"}, rd(16'h0668), 16'd7);
    check_val({tag, "_l1"}, rd(16'h066A), 16'd8);
    check_val({tag, "_l2"}, rd(16'h066C), 16'd9);
    check_val({tag, "_cnt"}, rd(A_BCNT), 16'd3);
    check_val({tag, "_bv"}, bestvalue, 16'd4);
    check_val({tag, "_bid"}, bestneighborID, 16'd8);
    check_val({tag, "_hop"}, besthop, 16'd1);
    check_val({tag, "_sink"}, nextsinks, 16'd4);
    check_val({tag, "_nwr"}, 16'(n_wr), 16'd4);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    nrst       = 1'b1;
    start      = 1'b0;
    load_mem   = 1'b0;
    my_cluster = 16'd1;
    mybest     = 16'd10;

    // Reset state
    clear_img(16'd0);
    load_and_reset();
    @(negedge clock);
    check_val("rst_addr", address, 16'h0000);
    check_val("rst_wr", {15'd0, wr_en}, 16'd0);
    check_val("rst_dout", data_out, 16'h0000);
    check_val("rst_done", {15'd0, done}, 16'd0);
    check_val("rst_hop", besthop, 16'h0000);
    check_val("rst_bv", bestvalue, 16'hFFFF);
    check_val("rst_bid", bestneighborID, 16'hFFFF);
    check_val("rst_sink", nextsinks, 16'h0000);

    // N=0: a single write of 0 to the count word
    run("n0");
    check_val("n0_nwr", 16'(n_wr), 16'd1);
    check_val("n0_cnt", rd(A_BCNT), 16'd0);
    check_val("n0_bv", bestvalue, 16'hFFFF);
    check_val("n0_bid", bestneighborID, 16'hFFFF);
    // start while in DONE changes nothing
    start = 1'b1;
    repeat (5) @(negedge clock);
    start = 1'b0;
    check_val("n0_hold_done", {15'd0, done}, 16'd1);
    check_val("n0_hold_nwr", 16'(n_wr), 16'd1);

    // Mixed clusters and q values
    clear_img(16'd3);
    set_nbr(0, 16'd1, 16'd5, 16'd7, 16'd2);
    set_nbr(1, 16'd2, 16'd3, 16'd8, 16'd4);
    set_nbr(2, 16'd1, 16'd12, 16'd9, 16'd6);
    load_and_reset();
    run("mix");
    check_val("mix_l0", rd(16'h0668), 16'd7);
    check_val("mix_l1", rd(16'h066A), 16'd0);
    check_val("mix_cnt", rd(A_BCNT), 16'd1);
    check_val("mix_bv", bestvalue, 16'd5);
    check_val("mix_bid", bestneighborID, 16'd7);
    check_val("mix_hop", besthop, 16'd0);
    check_val("mix_sink", nextsinks, 16'd2);

    // All same cluster, best in the middle
    setup_three();
    load_and_reset();
    run("all3");
    check_three("all3");

    // Equality with mybest and a best-value tie
    clear_img(16'd3);
    set_nbr(0, 16'd1, 16'd10, 16'd7, 16'd1);
    set_nbr(1, 16'd1, 16'd4, 16'd8, 16'd2);
    set_nbr(2, 16'd1, 16'd4, 16'd9, 16'd3);
    load_and_reset();
    run("eq");
    check_val("eq_bv", bestvalue, 16'd4);
`ifdef BNIMC_EQUAL_BETTER_EN
    check_val("eq_l0", rd(16'h0668), 16'd7);
    check_val("eq_l1", rd(16'h066A), 16'd8);
    check_val("eq_l2", rd(16'h066C), 16'd9);
    check_val("eq_cnt", rd(A_BCNT), 16'd3);
    check_val("eq_bid", bestneighborID, 16'd9);
    check_val("eq_hop", besthop, 16'd2);
    check_val("eq_sink", nextsinks, 16'd3);
`else
    check_val("eq_l0", rd(16'h0668), 16'd8);
    check_val("eq_l1", rd(16'h066A), 16'd9);
    check_val("eq_l2", rd(16'h066C), 16'd0);
    check_val("eq_cnt", rd(A_BCNT), 16'd2);
    check_val("eq_bid", bestneighborID, 16'd8);
    check_val("eq_hop", besthop, 16'd1);
    check_val("eq_sink", nextsinks, 16'd2);
`endif

    // 20 qualifying neighbours: list saturates at 16, best is the last one
    clear_img(16'd20);
    mybest = 16'd200;
    for (int j = 0; j < 20; j++)
      set_nbr(j, 16'd1, 16'(100 - j), 16'(16'h0100 + j), 16'(16'h0200 + j));
    load_and_reset();
    run("n20");
    check_val("n20_nwr", 16'(n_wr), 16'd17);
    check_val("n20_cnt", rd(A_BCNT), 16'd16);
    check_val("n20_l0", rd(16'h0668), 16'h0100);
    check_val("n20_l15", rd(16'h0686), 16'h010F);
    check_val("n20_past", rd(16'h0688), 16'hBEEF);
    check_val("n20_bv", bestvalue, 16'd81);
    check_val("n20_bid", bestneighborID, 16'h0113);
    check_val("n20_hop", besthop, 16'd19);
    check_val("n20_sink", nextsinks, 16'h0213);

    // Reset in the middle of a scan, then a clean re-run
    mybest = 16'd10;
    setup_three();
    load_and_reset();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (12) @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);
    check_val("mid_wr", {15'd0, wr_en}, 16'd0);
    check_val("mid_done", {15'd0, done}, 16'd0);
    check_val("mid_addr", address, 16'h0000);
    check_val("mid_bv", bestvalue, 16'hFFFF);
    check_val("mid_bid", bestneighborID, 16'hFFFF);
    check_val("mid_hop", besthop, 16'h0000);
    load_and_reset();
    run("rerun");
    check_three("rerun");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
